// File: rtl/xcorr_snapshot.sv
// Lag cross-correlator over all channel pairs with per-frame integration and a
// single snapshot buffer streamed out on a valid/ready interface.
module xcorr_snapshot #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned WORD_WIDTH = 1,
  parameter int unsigned LAG_CROSS  = 4,
  parameter int unsigned RESOLUTION = 24,
  parameter int unsigned INT_WIDTH  = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             smpclk,
  input  logic [WORD_WIDTH*NUM_INPUTS-1:0] adc_data,
  input  logic [INT_WIDTH-1:0]             integration,
  output logic [RESOLUTION-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             frame_dropped
);
  localparam int unsigned N            = NUM_INPUTS;
  localparam int unsigned W            = WORD_WIDTH;
  localparam int unsigned R            = RESOLUTION;
  localparam int unsigned NLAG         = 2 * LAG_CROSS - 1;
  localparam int unsigned NB           = N * (N - 1) / 2;
  localparam int unsigned NBIN         = NB * NLAG;
  localparam int unsigned CTR          = LAG_CROSS - 1;
  localparam int unsigned PW           = 2 * (W + 1);
  localparam int unsigned SW           = ((R > PW) ? R : PW) + 2;
  localparam int unsigned PRIME_SHIFTS = NLAG - 1;
  localparam int unsigned PCW          = $clog2(NLAG + 1);
  localparam int unsigned RIW          = $clog2(NBIN + 1);
  localparam logic signed [SW-1:0] POS_LIM = {{(SW - R + 1){1'b0}}, {(R - 1){1'b1}}};
  localparam logic signed [SW-1:0] NEG_LIM = -POS_LIM;

  typedef enum logic {ST_PRIME, ST_INTEGRATE} state_e;

  state_e                state_q, state_d;
  logic                  enter_int;
  logic                  shift;
  logic [W-1:0]          dl_q [N][NLAG];
  logic [PCW-1:0]        prime_cnt_q;
  logic                  acc_pend_q;
  logic [INT_WIDTH-1:0]  cnt_q, len_q;
  logic [15:0]           frame_cnt_q;
  logic                  sat_q, dropped_q;
  logic signed [R-1:0]   acc_q   [NBIN];
  logic signed [PW-1:0]  prod_w  [NBIN];
  logic signed [SW-1:0]  sum_w   [NBIN];
  logic signed [R-1:0]   acc_sum [NBIN];
  logic                  acc_sat;
  logic [R-1:0]          snap_q  [NBIN];
  logic [1:0]            snap_stat_q;
  logic [RIW-1:0]        rd_idx_q;
  logic [R-1:0]          snap_word;
  logic [R-1:0]          out_data_q;
  logic                  out_valid_q, out_last_q, frame_dropped_q;
  logic                  frame_last, frame_end, buf_free, capture, drop;

  // 1-bit samples map to +/-1; wider samples are two's complement
  function automatic logic signed [W:0] dec(input logic [W-1:0] s);
    return (W == 1) ? {~s[0], {W{1'b1}}} : {s[W-1], s};
  endfunction

  assign shift      = smpclk & enable;
  assign frame_last = (len_q == '0) ? (cnt_q == '0) : (cnt_q == len_q - INT_WIDTH'(1));
  assign frame_end  = acc_pend_q & frame_last;
  assign buf_free   = ~out_valid_q | (out_ready & out_last_q);
  assign capture    = frame_end & buf_free;
  assign drop       = frame_end & ~buf_free;

  // Products of the centre tap of channel i against every tap of channel j
  for (genvar i = 0; i < N; i++) begin : g_i
    for (genvar j = i + 1; j < N; j++) begin : g_j
      localparam int unsigned B = i * N - (i * (i + 1)) / 2 + (j - i - 1);
      for (genvar k = 0; k < NLAG; k++) begin : g_k
        assign prod_w[B*NLAG+k] = PW'(dec(dl_q[i][CTR])) * PW'(dec(dl_q[j][k]));
      end
    end
  end

  // Saturating accumulate, symmetric limits
  always_comb begin
    acc_sat = 1'b0;
    for (int unsigned b = 0; b < NBIN; b++) begin
      sum_w[b] = SW'(acc_q[b]) + SW'(prod_w[b]);
      if (sum_w[b] > POS_LIM) begin
        acc_sum[b] = R'(POS_LIM);
        acc_sat    = 1'b1;
      end else if (sum_w[b] < NEG_LIM) begin
        acc_sum[b] = R'(NEG_LIM);
        acc_sat    = 1'b1;
      end else begin
        acc_sum[b] = R'(sum_w[b]);
      end
    end
  end

  always_comb begin
    snap_word = '0;
    for (int unsigned b = 0; b < NBIN; b++) begin
      if (rd_idx_q == RIW'(b)) snap_word = snap_q[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_PRIME;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    enter_int = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (PRIME_SHIFTS == 0) begin
          state_d   = ST_INTEGRATE;
          enter_int = 1'b1;
        end else if (shift && ((32'(prime_cnt_q) + 32'd1) == PRIME_SHIFTS)) begin
          state_d   = ST_INTEGRATE;
          enter_int = 1'b1;
        end
      end
      ST_INTEGRATE: state_d = ST_INTEGRATE;
      default:      state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < N; n++)
        for (int t = 0; t < NLAG; t++) dl_q[n][t] <= '0;
      for (int b = 0; b < NBIN; b++) begin
        acc_q[b]  <= '0;
        snap_q[b] <= '0;
      end
      prime_cnt_q     <= '0;
      acc_pend_q      <= 1'b0;
      cnt_q           <= '0;
      len_q           <= '0;
      frame_cnt_q     <= '0;
      sat_q           <= 1'b0;
      dropped_q       <= 1'b0;
      snap_stat_q     <= '0;
      rd_idx_q        <= '0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      if (shift) begin
        for (int n = 0; n < N; n++) begin
          dl_q[n][0] <= adc_data[n*W +: W];
          for (int t = 1; t < NLAG; t++) dl_q[n][t] <= dl_q[n][t-1];
        end
      end
      if (state_q == ST_PRIME && shift) prime_cnt_q <= prime_cnt_q + PCW'(1);
      acc_pend_q      <= shift && (state_q == ST_INTEGRATE);
      frame_dropped_q <= drop;
      if (enter_int) begin
        len_q <= integration;
        cnt_q <= '0;
      end

      // An accepted shift always completes its accumulate, even if enable drops
      if (acc_pend_q) begin
        if (frame_last) begin
          cnt_q       <= '0;
          len_q       <= integration;
          frame_cnt_q <= frame_cnt_q + 16'd1;
          sat_q       <= 1'b0;
          for (int b = 0; b < NBIN; b++) acc_q[b] <= '0;
          if (buf_free) begin
            for (int b = 0; b < NBIN; b++) snap_q[b] <= acc_sum[b];
            snap_stat_q <= {dropped_q, sat_q | acc_sat};
            dropped_q   <= 1'b0;
          end else begin
            dropped_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + INT_WIDTH'(1);
          sat_q <= sat_q | acc_sat;
          for (int b = 0; b < NBIN; b++) acc_q[b] <= acc_sum[b];
        end
      end

      // Readout: header, bins in index order, then status word
      if (capture) begin
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
        out_data_q  <= R'(frame_cnt_q);
        rd_idx_q    <= '0;
      end else if (out_valid_q && out_ready) begin
        if (out_last_q) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_data_q  <= '0;
        end else if (rd_idx_q == RIW'(NBIN)) begin
          out_data_q <= R'(snap_stat_q);
          out_last_q <= 1'b1;
        end else begin
          out_data_q <= snap_word;
          rd_idx_q   <= rd_idx_q + RIW'(1);
        end
      end
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign frame_dropped = frame_dropped_q;

endmodule

// File: doc/xcorr_snapshot.md
XCORR_SNAPSHOT -- requirements
Module: xcorr_snapshot

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, input channel count (2..8).
REQ-002 SHALL have parameter WORD_WIDTH, default 1, bits per sample (1..8).
REQ-003 SHALL have parameter LAG_CROSS, default 4, lag half-span; bins per baseline NLAG = 2*LAG_CROSS-1.
REQ-004 SHALL have parameter RESOLUTION, default 24, accumulator and output word width (8..32).
REQ-005 SHALL have parameter INT_WIDTH, default 24, width of integration length.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port enable  input  1  gates sample capture and accumulation.
REQ-009 SHALL have port smpclk  input  1  sample strobe, one-cycle pulse per sample.
REQ-010 SHALL have port adc_data  input  WORD_WIDTH*NUM_INPUTS  samples, channel n at [n*WORD_WIDTH +: WORD_WIDTH].
REQ-011 SHALL have port integration  input  INT_WIDTH  samples per frame, latched at frame start.
REQ-012 SHALL have port out_data  output  RESOLUTION  readout word.
REQ-013 SHALL have port out_valid / out_ready / out_last  output/input/output  1 each  readout stream handshake, out_last on final word.
REQ-014 SHALL have port frame_dropped  output  1  one-cycle pulse when a completed frame is discarded.

Function
REQ-015 SHALL decode samples: WORD_WIDTH=1 bit 1 -> +1, bit 0 -> -1; WORD_WIDTH>1 two's complement.
REQ-016 SHALL keep per channel a delay line d[t], t=0..NLAG-1 (t=0 newest), shifting on clk edge where smpclk & enable.
REQ-017 SHALL order baselines (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1); NB = N*(N-1)/2; bin index b*NLAG+k.
REQ-018 SHALL add d_i[LAG_CROSS-1]*d_j[k] to bin (i,j,k) on the cycle after each shift (one-cycle pipeline).
REQ-019 SHALL sign-extend products to RESOLUTION and saturate accumulators at +(2^(RESOLUTION-1)-1) / -(2^(RESOLUTION-1)-1); any clamp sets sticky sat flag for the frame.
REQ-020 SHALL implement states PRIME -> INTEGRATE: PRIME counts NLAG-1 shifts without accumulating, then INTEGRATE.
REQ-021 SHALL in INTEGRATE count accumulated samples; integration=0 treated as 1.
REQ-022 SHALL on the accumulate cycle of the last sample of a frame, copy all bins into snapshot buffer if empty, clear accumulators, increment 16-bit frame counter; next sample starts new frame with no sample lost.
REQ-023 SHALL, if snapshot buffer still occupied at frame end, discard the frame, clear accumulators, pulse frame_dropped, still increment frame counter.
REQ-024 SHALL stream snapshot starting the cycle after copy: word 0 = {zero-extended frame counter}, words 1..NB*NLAG = bins in index order, final word = {sat flag bit0, dropped-since-last-readout bit1, zeros}, out_last high on final word only.
REQ-025 SHALL advance a word only when out_valid & out_ready; out_data stable while out_valid & ~out_ready.
REQ-026 SHALL free the snapshot buffer on the cycle the out_last word is accepted; a frame ending that same cycle SHALL be captured, not dropped.
REQ-027 SHALL when enable low hold accumulators, counters and delay lines; readout continues.

Reset
REQ-028 SHALL on reset: out_valid=0, out_last=0, out_data=0, frame_dropped=0, accumulators, snapshot, sat/dropped flags, counters cleared, delay lines zero, state PRIME.
REQ-029 SHALL on reset mid-readout deassert out_valid the following cycle and discard remaining words.

Verification (N=2, WORD_WIDTH=1, LAG_CROSS=2, RESOLUTION=8, NLAG=3)
REQ-030 All inputs 1, integration=4, out_ready=1 -> stream 0x00, 4, 4, 4, 0x00, out_last on 5th word.
REQ-031 Ch0 all 1, ch1 all 0, integration=4 -> bins -4,-4,-4 (0xFC), status 0x00.
REQ-032 All inputs 1, integration=200 -> bins 127 each, status 0x01.
REQ-033 integration=2, out_ready=0 for 10 strobes -> first frame held stable, frame_dropped pulses, status of held frame 0x00, next streamed frame status 0x02.
REQ-034 Reset asserted on 2nd readout word -> out_valid 0 next cycle; after reset, 1 strobe gives no accumulation (PRIME), frame counter restarts at 0.
